// File: rtl/uart_program_loader_pkg.sv
// Shared definitions for the UART boot loader: sync byte, default bit period
// and the state encodings of the frame parser and the byte receiver.
package uart_program_loader_pkg;

    localparam logic [7:0] LOADER_SYNC    = 8'hA5;
    localparam int         LOADER_CLK_DIV = 868;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN_LO,
        ST_LEN_HI,
        ST_DATA,
        ST_CSUM,
        ST_DONE,
        ST_ERROR
    } loader_state_e;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_e;

endpackage

// File: rtl/uart_program_loader_if.sv
// Memory write port driven by the loader (master) into the block RAM (slave).
interface uart_program_loader_if #(
    parameter int ADDR_WIDTH = 10
) ();

    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [31:0]           mem_data;
    logic                  mem_en;
    logic [3:0]            mem_we_mask;

    modport master (
        output mem_addr,
        output mem_data,
        output mem_en,
        output mem_we_mask
    );

    modport slave (
        input mem_addr,
        input mem_data,
        input mem_en,
        input mem_we_mask
    );

endinterface

// File: rtl/uart_program_loader_uart_rx.sv
// 8N1 UART receiver: 2-flop synchroniser, mid-bit sampling timer, LSB-first shifter.
// byte_valid pulses one cycle after the stop sample; frame_err qualifies it.
module uart_rx
    import uart_program_loader_pkg::*;
#(
    parameter int CLK_DIV = LOADER_CLK_DIV
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       frame_err
);

    localparam int            CW   = $clog2(CLK_DIV);
    localparam logic [CW-1:0] FULL = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] HALF = CW'(CLK_DIV / 2 - 1);

    logic          sync1_q, sync2_q, prev_q;
    rx_state_e     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          valid_q, valid_d;
    logic          ferr_q, ferr_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
            state_q <= RX_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            sync1_q <= rx;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        case (state_q)
            RX_IDLE: begin
                if (prev_q && !sync2_q) begin
                    state_d = RX_START;
                    cnt_d   = '0;
                end
            end
            RX_START: begin
                // A start bit that is already high again at mid-bit was a glitch.
                if (cnt_q == HALF) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = sync2_q ? RX_IDLE : RX_DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RX_DATA: begin
                if (cnt_q == FULL) begin
                    cnt_d   = '0;
                    shift_d = {sync2_q, shift_q[7:1]};
                    bit_d   = bit_q + 1'b1;
                    if (bit_q == 3'd7) state_d = RX_STOP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RX_STOP: begin
                if (cnt_q == FULL) begin
                    cnt_d   = '0;
                    valid_d = 1'b1;
                    ferr_d  = !sync2_q;
                    state_d = RX_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    assign byte_valid = valid_q;
    assign byte_data  = shift_q;
    assign frame_err  = ferr_q;

endmodule

// File: rtl/uart_program_loader.sv
// Boot-time program loader: parses A5/len/data/checksum frames from the UART,
// writes little-endian words to RAM and releases cpu_rst once the image verifies.
module uart_program_loader
    import uart_program_loader_pkg::*;
#(
    parameter int CLK_DIV    = LOADER_CLK_DIV,
    parameter int ADDR_WIDTH = 10,
    parameter int D_WIDTH    = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rx,
    uart_program_loader_if.master  mem,
    output logic                   cpu_rst,
    output logic                   busy,
    output logic                   done,
    output logic                   err
);

    logic       byte_valid;
    logic [7:0] byte_data;
    logic       frame_err;

    uart_rx #(.CLK_DIV(CLK_DIV)) u_rx (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .frame_err  (frame_err)
    );

    loader_state_e         state_q, state_d;
    logic [ADDR_WIDTH-1:0] idx_q, idx_d;
    logic [ADDR_WIDTH:0]   nwords_q, nwords_d;
    logic [1:0]            bcnt_q, bcnt_d;
    logic [D_WIDTH-1:0]    data_q, data_d;
    logic [7:0]            csum_q, csum_d;
    logic [7:0]            len_lo_q, len_lo_d;
    logic                  en_q, en_d;
    logic                  err_q, err_d;

    logic                  accept, bad;
    logic [15:0]           n_full;
    logic                  last_word;

    assign accept    = byte_valid && !frame_err;
    assign bad       = byte_valid && frame_err;
    assign n_full    = {byte_data, len_lo_q};
    assign last_word = ({1'b0, idx_q} + 1'b1) == nwords_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            nwords_q <= '0;
            bcnt_q   <= '0;
            data_q   <= '0;
            csum_q   <= '0;
            len_lo_q <= '0;
            en_q     <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            nwords_q <= nwords_d;
            bcnt_q   <= bcnt_d;
            data_q   <= data_d;
            csum_q   <= csum_d;
            len_lo_q <= len_lo_d;
            en_q     <= en_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        nwords_d = nwords_q;
        bcnt_d   = bcnt_q;
        data_d   = data_q;
        csum_d   = csum_q;
        len_lo_d = len_lo_q;
        en_d     = 1'b0;
        err_d    = err_q;

        // The address advances only after the write strobe has been presented.
        if (en_q) idx_d = idx_q + 1'b1;

        case (state_q)
            ST_IDLE: begin
                if (accept && byte_data == LOADER_SYNC) begin
                    state_d = ST_LEN_LO;
                    err_d   = 1'b0;
                    idx_d   = '0;
                    bcnt_d  = '0;
                    csum_d  = '0;
                end
            end
            ST_LEN_LO: begin
                if (bad) begin
                    state_d = ST_ERROR;
                end else if (accept) begin
                    len_lo_d = byte_data;
                    state_d  = ST_LEN_HI;
                end
            end
            ST_LEN_HI: begin
                if (bad) begin
                    state_d = ST_ERROR;
                end else if (accept) begin
                    if (32'(n_full) > (32'd1 << ADDR_WIDTH)) begin
                        state_d = ST_ERROR;
                    end else if (n_full == 16'd0) begin
                        state_d = ST_CSUM;
                    end else begin
                        nwords_d = n_full[ADDR_WIDTH:0];
                        state_d  = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (bad) begin
                    state_d = ST_ERROR;
                end else if (accept) begin
                    data_d[{bcnt_q, 3'b000} +: 8] = byte_data;
                    csum_d = csum_q + byte_data;
                    bcnt_d = bcnt_q + 1'b1;
                    if (bcnt_q == 2'd3) begin
                        en_d = 1'b1;
                        if (last_word) state_d = ST_CSUM;
                    end
                end
            end
            ST_CSUM: begin
                if (bad) begin
                    state_d = ST_ERROR;
                end else if (accept) begin
                    state_d = (byte_data == csum_q) ? ST_DONE : ST_ERROR;
                end
            end
            ST_DONE:  state_d = ST_DONE;
            ST_ERROR: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase

        if (state_d == ST_ERROR) err_d = 1'b1;
    end

    assign mem.mem_addr    = idx_q;
    assign mem.mem_data    = data_q;
    assign mem.mem_en      = en_q;
    assign mem.mem_we_mask = {4{en_q}};

    assign done    = (state_q == ST_DONE);
    assign cpu_rst = !done;
    assign busy    = (state_q == ST_LEN_LO) || (state_q == ST_LEN_HI) ||
                     (state_q == ST_DATA)   || (state_q == ST_CSUM);
    assign err     = err_q;

endmodule

// File: tb/tb_uart_program_loader.sv
// Directed bench for uart_program_loader at CLK_DIV=16 with a write-port monitor.
module tb_uart_program_loader;
    import uart_program_loader_pkg::*;

    localparam int CLK_DIV = 16;
    localparam int AW      = 10;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic rx    = 1'b1;
    logic cpu_rst, busy, done, err;

    int checks   = 0;
    int failures = 0;

    uart_program_loader_if #(.ADDR_WIDTH(AW)) mem_if ();

    uart_program_loader #(.CLK_DIV(CLK_DIV), .ADDR_WIDTH(AW), .D_WIDTH(32)) dut (
        .clk     (clk),
        .rst     (rst_n),
        .rx      (rx),
        .mem     (mem_if),
        .cpu_rst (cpu_rst),
        .busy    (busy),
        .done    (done),
        .err     (err)
    );

    always #5 clk = ~clk;

    // Every cycle with mem_en high is logged, so a stretched strobe shows as an extra write.
    int          nwr = 0;
    logic [31:0] wr_addr [256];
    logic [31:0] wr_data [256];
    logic [31:0] wr_mask [256];

    always @(negedge clk) begin
        if (mem_if.mem_en === 1'b1) begin
            if (nwr < 256) begin
                wr_addr[nwr] <= 32'(mem_if.mem_addr);
                wr_data[nwr] <= mem_if.mem_data;
                wr_mask[nwr] <= 32'(mem_if.mem_we_mask);
            end
            nwr <= nwr + 1;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        repeat (CLK_DIV) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop = 1'b1);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(stop);
        if (!stop) send_bit(1'b1);
    endtask

    task automatic send_seq(input logic [7:0] q[$]);
        foreach (q[i]) send_byte(q[i]);
        repeat (4) @(negedge clk);
    endtask

    task automatic check_wr(input string tag, input int i, input logic [31:0] a, input logic [31:0] d);
        check_val({tag, "_addr"}, wr_addr[i], a);
        check_val({tag, "_data"}, wr_data[i], d);
        check_val({tag, "_mask"}, wr_mask[i], 32'hF);
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_addr"},    32'(mem_if.mem_addr), 32'h0);
        check_val({tag, "_data"},    mem_if.mem_data, 32'h0);
        check_val({tag, "_en"},      32'(mem_if.mem_en), 32'h0);
        check_val({tag, "_mask"},    32'(mem_if.mem_we_mask), 32'h0);
        check_val({tag, "_cpu_rst"}, 32'(cpu_rst), 32'h1);
        check_val({tag, "_busy"},    32'(busy), 32'h0);
        check_val({tag, "_done"},    32'(done), 32'h0);
        check_val({tag, "_err"},     32'(err), 32'h0);
    endtask

    int base;

    initial begin
        // Frame A: two words, checksum 13+93+10 = B6
        logic [7:0] body_a[$];
        body_a = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};

        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Good two-word image
        base = nwr;
        send_byte(8'hA5);
        check_val("a_busy_after_sync", 32'(busy), 32'h1);
        check_val("a_cpu_rst_loading", 32'(cpu_rst), 32'h1);
        send_seq({body_a, 8'hB6});
        check_val("a_nwr", 32'(nwr - base), 32'd2);
        check_wr("a_w0", base, 32'd0, 32'h0000_0013);
        check_wr("a_w1", base + 1, 32'd1, 32'h0010_0093);
        check_val("a_done", 32'(done), 32'h1);
        check_val("a_cpu_rst", 32'(cpu_rst), 32'h0);
        check_val("a_busy", 32'(busy), 32'h0);
        check_val("a_err", 32'(err), 32'h0);

        // DONE ignores further traffic
        send_seq('{8'hA5, 8'h01});
        check_val("done_ignore_busy", 32'(busy), 32'h0);
        check_val("done_ignore_done", 32'(done), 32'h1);
        check_val("done_ignore_nwr", 32'(nwr - base), 32'd2);
        pulse_reset();

        // Bad checksum, then recovery with the correct frame
        base = nwr;
        send_byte(8'hA5);
        send_seq({body_a, 8'hB7});
        check_val("b_nwr", 32'(nwr - base), 32'd2);
        check_val("b_err", 32'(err), 32'h1);
        check_val("b_cpu_rst", 32'(cpu_rst), 32'h1);
        check_val("b_done", 32'(done), 32'h0);
        send_byte(8'hA5);
        check_val("b_err_cleared_by_sync", 32'(err), 32'h0);
        check_val("b_busy_resync", 32'(busy), 32'h1);
        send_seq({body_a, 8'hB6});
        check_val("b_nwr_total", 32'(nwr - base), 32'd4);
        check_wr("b_w0", base + 2, 32'd0, 32'h0000_0013);
        check_wr("b_w1", base + 3, 32'd1, 32'h0010_0093);
        check_val("b_done", 32'(done), 32'h1);
        pulse_reset();

        // Leading garbage before sync; checksum 78+56+34+12 = 0x114 -> 14
        base = nwr;
        send_seq('{8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h01, 8'h00,
                   8'h78, 8'h56, 8'h34, 8'h12, 8'h14});
        check_val("c_nwr", 32'(nwr - base), 32'd1);
        check_wr("c_w0", base, 32'd0, 32'h1234_5678);
        check_val("c_done", 32'(done), 32'h1);
        pulse_reset();

        // Count 0x0401 exceeds 1024 words
        base = nwr;
        send_seq('{8'hA5, 8'h01, 8'h04});
        check_val("d_err", 32'(err), 32'h1);
        check_val("d_busy", 32'(busy), 32'h0);
        check_val("d_cpu_rst", 32'(cpu_rst), 32'h1);
        send_seq('{8'h11, 8'h22, 8'h33, 8'h44});
        check_val("d_nwr", 32'(nwr - base), 32'd0);

        // Framing error on the third data byte
        base = nwr;
        send_seq('{8'hA5, 8'h01, 8'h00, 8'h11, 8'h22});
        send_byte(8'h33, 1'b0);
        repeat (4) @(negedge clk);
        check_val("e_err", 32'(err), 32'h1);
        check_val("e_busy", 32'(busy), 32'h0);
        check_val("e_partial", mem_if.mem_data, 32'h0000_2211);
        check_val("e_nwr", 32'(nwr - base), 32'd0);
        pulse_reset();

        // 3-cycle glitch inside a frame must not be taken as a byte; EF+BE+AD+DE = 0x338 -> 38
        base = nwr;
        send_byte(8'hA5);
        rx = 1'b0;
        repeat (3) @(negedge clk);
        rx = 1'b1;
        repeat (2 * CLK_DIV) @(negedge clk);
        send_seq('{8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h38});
        check_val("f_nwr", 32'(nwr - base), 32'd1);
        check_wr("f_w0", base, 32'd0, 32'hDEAD_BEEF);
        check_val("f_done", 32'(done), 32'h1);
        pulse_reset();

        // Reset in the middle of DATA, then a full reload from address 0
        send_seq('{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00});
        rst_n = 1'b0;
        #1;
        check_reset_outputs("g_midrst");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        base = nwr;
        send_byte(8'hA5);
        send_seq({body_a, 8'hB6});
        check_val("g_nwr", 32'(nwr - base), 32'd2);
        check_wr("g_w0", base, 32'd0, 32'h0000_0013);
        check_wr("g_w1", base + 1, 32'd1, 32'h0010_0093);
        check_val("g_done", 32'(done), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
